hdec_pipe: RTL and testbench
============================

HDEC_PIPE -- requirements
Module: hdec_pipe

Interface
REQ-001 The block SHALL take parameter N, default 4, meaning the width of the binary input operand (legal range 1..8).
REQ-002 The block SHALL derive local parameter W = 2**N, the output vector width, and P = smallest power of two >= N, the internal padded width used for the high/low split.
REQ-003 The block SHALL have a single clock and a synchronous, active-high reset.
REQ-004 clk  input  1  sole clock; all state updates on the rising edge.
REQ-005 rst  input  1  synchronous, active-high reset.
REQ-006 in_valid  input  1  upstream offers an operand.
REQ-007 in_ready  output  1  block accepts the operand this cycle.
REQ-008 in_x  input  N  unsigned operand x.
REQ-009 in_mode  input  2  decode mode: 0 = half-decode, 1 = one-hot, 2 = inverted half-decode, 3 = reserved.
REQ-010 out_valid  output  1  result available.
REQ-011 out_ready  input  1  downstream accepts the result.
REQ-012 out_y  output  W  decoded vector.
REQ-013 out_cnt  output  32  accepted-result count; present only when HDEC_PIPE_CNT_EN is defined.

Function
REQ-014 An input transfer SHALL occur on a cycle with in_valid=1 and in_ready=1; an output transfer SHALL occur on a cycle with out_valid=1 and out_ready=1.
REQ-015 Mode 0 SHALL produce out_y[i]=1 iff i < x, so x=0 gives all zeros.
REQ-016 Mode 1 SHALL produce out_y[i]=1 iff i == x.
REQ-017 Mode 2 SHALL produce out_y[i]=1 iff i >= x, the bitwise complement of mode 0.
REQ-018 Mode 3 SHALL produce all zeros.
REQ-019 Stage 1 SHALL register, for the zero-extended P-bit operand, the high-half and low-half sub-decodes (one-hot and half-decode of each half) together with the mode.
REQ-020 Stage 2 SHALL combine the stage-1 registers into out_y and register the result.
REQ-021 No combinational path SHALL exist from in_x to out_y.
REQ-022 The latency SHALL be exactly 2 cycles from an input transfer to out_valid=1, provided out_ready=1.
REQ-023 Sustained throughput SHALL be one transfer per cycle.
REQ-024 Each stage SHALL hold a valid bit.
REQ-025 Stage 2 SHALL advance when it is empty or when an output transfer occurs in the same cycle.
REQ-026 Stage 1 SHALL advance when it is empty or when stage 2 advances.
REQ-027 in_ready SHALL equal the stage-1 advance condition.
REQ-028 With out_ready=0 and both stages full, in_ready SHALL be 0, and out_y and out_valid SHALL hold stable.
REQ-029 When the pipeline is full, an output transfer and an input transfer SHALL both be allowed in the same cycle, with no bubble inserted.
REQ-030 Results SHALL leave in acceptance order; none SHALL be dropped or duplicated.
REQ-031 For N not a power of two, the padded high bits SHALL be zero, and out_y SHALL depend only on the W-bit result.

Reset
REQ-032 While rst=1, both valid bits, out_valid and in_ready SHALL be 0.
REQ-033 While rst=1, out_y SHALL be all zeros and out_cnt SHALL be 0.
REQ-034 In-flight operands SHALL be discarded on reset, including a reset asserted mid-stall.
REQ-035 in_ready SHALL be 1 on the first cycle after rst deasserts.

Configuration
REQ-036 The macro HDEC_PIPE_CNT_EN SHALL control the result counter.
REQ-037 With HDEC_PIPE_CNT_EN defined, port out_cnt SHALL exist and SHALL increment by 1 on every output transfer, wrapping from 0xFFFFFFFF to 0.
REQ-038 Without HDEC_PIPE_CNT_EN, the port and counter SHALL be absent, and all other behaviour SHALL be identical.

Verification
REQ-039 Exhaustive decode: N=4, out_ready=1, stream x=0..15 in each of modes 0/1/2 -> e.g. mode 0, x=5 gives out_y=0x001F; mode 1, x=5 gives 0x0020; mode 2, x=5 gives 0xFFE0; each result 2 cycles after its input transfer.
REQ-040 Boundaries: N=4, mode 0, x=0 -> 0x0000; mode 0, x=15 -> 0x7FFF; mode 1, x=15 -> 0x8000; mode 3, any x -> 0x0000.
REQ-041 Backpressure: out_ready=0 with continuous in_valid -> in_ready=0 after 2 accepts and out_y holds the first result; raising out_ready -> the results of x=3, 7, 9 emerge in that order with no loss.
REQ-042 Reset mid-stall: both stages full, then rst=1 for 1 cycle -> out_valid=0 and out_y=0 next cycle, in_ready=1 after release, and no stale result appears.
REQ-043 Non-power-of-two width: N=3, all 8 values in mode 0 -> W=8 and x=3 gives 0x07; x=7 gives 0x7F.
REQ-044 Counter: with HDEC_PIPE_CNT_EN, 20 output transfers under random out_ready -> out_cnt=20; force the counter to 0xFFFFFFFF, then 1 transfer -> out_cnt=0.

Source files
------------

// File: rtl/hdec_pipe.sv
// -----------------------------------------------------------------------------
// hdec_pipe -- two-stage pipelined thermometer / one-hot decoder
//
// Purpose:
//   Decodes an unsigned N-bit operand x into a W = 2**N bit vector:
//     mode 0 : out_y[i] = (i <  x)   half-decode (thermometer)
//     mode 1 : out_y[i] = (i == x)   one-hot
//     mode 2 : out_y[i] = (i >= x)   inverted half-decode
//     mode 3 : all zeros             reserved
//   The operand is zero-extended to a power-of-two width and split into
//   high and low halves. Stage 1 registers the small one-hot and half-decodes
//   of each half. Stage 2 combines them into the wide vector and registers it.
//   Valid/ready handshake on both sides, one transfer per cycle sustained,
//   latency 2 cycles.
//
// Ports:
//   clk        in   1   sole clock, rising edge
//   rst        in   1   synchronous active-high reset
//   in_valid   in   1   upstream offers an operand
//   in_ready   out  1   operand accepted this cycle
//   in_x       in   N   unsigned operand
//   in_mode    in   2   decode mode (see above)
//   out_valid  out  1   result available
//   out_ready  in   1   downstream accepts result
//   out_y      out  W   decoded vector
//   out_cnt    out  32  accepted-result count (only with HDEC_PIPE_CNT_EN)
//
// Configuration macro:
//   HDEC_PIPE_CNT_EN  -- when defined, adds the out_cnt port and the
//                        wrapping 32-bit output-transfer counter.
// -----------------------------------------------------------------------------
module hdec_pipe #(
   parameter int N = 4
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                in_valid,
   output logic                in_ready,
   input  logic [N-1:0]        in_x,
   input  logic [1:0]          in_mode,
   output logic                out_valid,
   input  logic                out_ready,
   output logic [(2**N)-1:0]   out_y
`ifdef HDEC_PIPE_CNT_EN
   ,
   output logic [31:0]         out_cnt
`endif
);

   localparam int W  = 2**N;
   // smallest power of two >= N (legal N is 1..8)
   localparam int P  = (N <= 1) ? 1 : (N <= 2) ? 2 : (N <= 4) ? 4 : 8;
   // a 1-bit operand cannot be split, so it is padded to 2 bits for the split
   localparam int PS = (P < 2) ? 2 : P;
   localparam int H  = PS / 2;      // width of each half
   localparam int L  = 2**H;        // width of each sub-decode
   localparam int F  = 2**PS;       // width of the full combined decode (>= W)

   // one-hot sub-decode of an H-bit value
   function automatic logic [L-1:0] sub_onehot(input logic [H-1:0] v);
      logic [L-1:0] r;
      r = '0;
      for (int i = 0; i < L; i++) begin
         r[i] = (v == H'(i));
      end
      return r;
   endfunction

   // half-decode (bit i set iff i < v) of an H-bit value
   function automatic logic [L-1:0] sub_halfdec(input logic [H-1:0] v);
      logic [L-1:0] r;
      r = '0;
      for (int i = 0; i < L; i++) begin
         r[i] = (H'(i) < v);
      end
      return r;
   endfunction

   // ---------------------------------------------------------------- handshake
   logic          w_s2_adv;
   logic          w_s1_adv;
   logic          w_in_fire;
   logic          w_out_fire;

   logic          r_s1_valid;
   logic [1:0]    r_s1_mode;
   logic [L-1:0]  r_s1_oh_lo;
   logic [L-1:0]  r_s1_hd_lo;
   logic [L-1:0]  r_s1_oh_hi;
   logic [L-1:0]  r_s1_hd_hi;

   logic          r_s2_valid;
   logic [W-1:0]  r_s2_y;

   logic [PS-1:0] w_x_pad;
   logic [H-1:0]  w_x_lo;
   logic [H-1:0]  w_x_hi;

   logic [F-1:0]  w_lt;
   logic [F-1:0]  w_eq;
   logic [W-1:0]  w_y;
   logic          w_pad_unused;

   assign w_s2_adv   = ~r_s2_valid | out_ready;
   assign w_s1_adv   = ~r_s1_valid | w_s2_adv;
   // reset is folded in so the upstream sees no acceptance while rst is high
   assign in_ready   = w_s1_adv & ~rst;
   assign w_in_fire  = in_valid & in_ready;
   assign out_valid  = r_s2_valid & ~rst;
   assign out_y      = rst ? '0 : r_s2_y;
   assign w_out_fire = out_valid & out_ready;

   // ------------------------------------------------------------ operand split
   // zero-extension keeps the padded high bits at zero for non-power-of-two N
   assign w_x_pad = PS'(in_x);
   assign w_x_lo  = w_x_pad[H-1:0];
   assign w_x_hi  = w_x_pad[PS-1:H];

   // Stage 1: register sub-decodes of both halves plus the mode
   always_ff @(posedge clk) begin
      if (rst) begin
         r_s1_valid <= 1'b0;
         r_s1_mode  <= 2'd0;
         r_s1_oh_lo <= '0;
         r_s1_hd_lo <= '0;
         r_s1_oh_hi <= '0;
         r_s1_hd_hi <= '0;
      end else if (w_s1_adv) begin
         r_s1_valid <= w_in_fire;
         if (w_in_fire) begin
            r_s1_mode  <= in_mode;
            r_s1_oh_lo <= sub_onehot(w_x_lo);
            r_s1_hd_lo <= sub_halfdec(w_x_lo);
            r_s1_oh_hi <= sub_onehot(w_x_hi);
            r_s1_hd_hi <= sub_halfdec(w_x_hi);
         end
      end
   end

   // Stage 2 combine: index i = hi*L + lo; i < x iff hi < x_hi, or hi == x_hi and lo < x_lo
   always_comb begin
      w_lt = '0;
      w_eq = '0;
      for (int ih = 0; ih < L; ih++) begin
         for (int il = 0; il < L; il++) begin
            w_lt[ih*L + il] = r_s1_hd_hi[ih] | (r_s1_oh_hi[ih] & r_s1_hd_lo[il]);
            w_eq[ih*L + il] = r_s1_oh_hi[ih] & r_s1_oh_lo[il];
         end
      end
   end

   // Stage 2 mode select over the W-bit result only
   always_comb begin
      w_y = '0;
      case (r_s1_mode)
         2'd0:    w_y = w_lt[W-1:0];
         2'd1:    w_y = w_eq[W-1:0];
         2'd2:    w_y = ~w_lt[W-1:0];
         default: w_y = '0;
      endcase
   end

   // bits above W exist only when N is not a power of two; they are never used
   assign w_pad_unused = ^{w_lt, w_eq};

   // Stage 2: register the decoded vector
   always_ff @(posedge clk) begin
      if (rst) begin
         r_s2_valid <= 1'b0;
         r_s2_y     <= '0;
      end else if (w_s2_adv) begin
         r_s2_valid <= r_s1_valid;
         if (r_s1_valid) begin
            r_s2_y <= w_y;
         end
      end
   end

`ifdef HDEC_PIPE_CNT_EN
   logic [31:0] r_cnt;

   // Output-transfer counter, wraps naturally at 32 bits
   always_ff @(posedge clk) begin
      if (rst) begin
         r_cnt <= 32'd0;
      end else if (w_out_fire) begin
         r_cnt <= r_cnt + 32'd1;
      end
   end

   assign out_cnt = rst ? 32'd0 : r_cnt;
`else
   logic w_fire_unused;
   assign w_fire_unused = w_out_fire;
`endif

endmodule

// File: tb/tb_hdec_pipe.sv
module tb_hdec_pipe;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst;

   logic        in_valid4, in_ready4, out_valid4, out_ready4;
   logic [3:0]  in_x4;
   logic [1:0]  in_mode4;
   logic [15:0] out_y4;

   logic        in_valid3, in_ready3, out_valid3, out_ready3;
   logic [2:0]  in_x3;
   logic [1:0]  in_mode3;
   logic [7:0]  out_y3;

`ifdef HDEC_PIPE_CNT_EN
   logic [31:0] out_cnt4;
   logic [31:0] out_cnt3;
`endif

   hdec_pipe #(.N(4)) dut4 (
      .clk(clk), .rst(rst),
      .in_valid(in_valid4), .in_ready(in_ready4), .in_x(in_x4), .in_mode(in_mode4),
      .out_valid(out_valid4), .out_ready(out_ready4), .out_y(out_y4)
`ifdef HDEC_PIPE_CNT_EN
      , .out_cnt(out_cnt4)
`endif
   );

   hdec_pipe #(.N(3)) dut3 (
      .clk(clk), .rst(rst),
      .in_valid(in_valid3), .in_ready(in_ready3), .in_x(in_x3), .in_mode(in_mode3),
      .out_valid(out_valid3), .out_ready(out_ready3), .out_y(out_y3)
`ifdef HDEC_PIPE_CNT_EN
      , .out_cnt(out_cnt3)
`endif
   );

   int checks = 0;
   int errors = 0;
   int cyc    = 0;
   bit lat_chk = 1'b0;
   bit rnd_on  = 1'b0;

   typedef struct {
      logic [31:0] y;
      int          c;
      bit          lat;
   } item_t;

   item_t q4[$];
   item_t q3[$];
   item_t it4, it3;

   // reference: decode rules evaluated bit by bit with integer comparisons
   function automatic logic [31:0] ref_y(input int n, input int x, input int m);
      logic [31:0] r;
      r = 32'd0;
      for (int i = 0; i < (1 << n); i++) begin
         case (m)
            0:       r[i] = (i <  x);
            1:       r[i] = (i == x);
            2:       r[i] = (i >= x);
            default: r[i] = 1'b0;
         endcase
      end
      return r;
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h required=%h", nm, act, exp);
      end
   endtask

   always @(posedge clk) cyc <= cyc + 1;

   // scoreboard push on input transfers
   always @(negedge clk) begin
      if (!rst && in_valid4 && in_ready4) q4.push_back('{ref_y(4, int'(in_x4), int'(in_mode4)), cyc, lat_chk});
      if (!rst && in_valid3 && in_ready3) q3.push_back('{ref_y(3, int'(in_x3), int'(in_mode3)), cyc, lat_chk});
   end

   // monitor: pop and compare on output transfers
   always @(negedge clk) begin
      if (!rst && out_valid4 && out_ready4) begin
         if (q4.size() == 0) begin
            checks++; errors++;
            $display("FAIL n4_unexpected_output actual=%h required=no_output", out_y4);
         end else begin
            it4 = q4.pop_front();
            chk("n4_y", {16'd0, out_y4}, it4.y);
            if (it4.lat) chk("n4_latency", cyc - it4.c, 32'd2);
         end
      end
      if (!rst && out_valid3 && out_ready3) begin
         if (q3.size() == 0) begin
            checks++; errors++;
            $display("FAIL n3_unexpected_output actual=%h required=no_output", out_y3);
         end else begin
            it3 = q3.pop_front();
            chk("n3_y", {24'd0, out_y3}, it3.y);
            if (it3.lat) chk("n3_latency", cyc - it3.c, 32'd2);
         end
      end
   end

   task automatic send4(input int x, input int m);
      bit ok;
      ok = 1'b0;
      in_x4 = 4'(x); in_mode4 = 2'(m); in_valid4 = 1'b1;
      for (int k = 0; k < 200; k++) begin
         @(negedge clk);
         if (in_ready4) begin ok = 1'b1; break; end
      end
      if (!ok) begin
         checks++; errors++;
         $display("FAIL n4_accept_timeout actual=in_ready_low required=accept");
      end
      @(posedge clk); #1;
      in_valid4 = 1'b0;
   endtask

   task automatic send3(input int x, input int m);
      bit ok;
      ok = 1'b0;
      in_x3 = 3'(x); in_mode3 = 2'(m); in_valid3 = 1'b1;
      for (int k = 0; k < 200; k++) begin
         @(negedge clk);
         if (in_ready3) begin ok = 1'b1; break; end
      end
      if (!ok) begin
         checks++; errors++;
         $display("FAIL n3_accept_timeout actual=in_ready_low required=accept");
      end
      @(posedge clk); #1;
      in_valid3 = 1'b0;
   endtask

   task automatic drain(input string nm);
      bit ok;
      ok = 1'b0;
      for (int k = 0; k < 300; k++) begin
         @(negedge clk);
         if (q4.size() == 0 && q3.size() == 0) begin ok = 1'b1; break; end
      end
      if (!ok) begin
         checks++; errors++;
         $display("FAIL %s_drain_timeout actual=%0d required=0", nm, q4.size() + q3.size());
      end
      @(posedge clk); #1;
   endtask

   // directed check on an empty pipeline: nothing one cycle in, result after two
   task automatic dir4(input int x, input int m, input logic [15:0] exp);
      send4(x, m);
      @(negedge clk);
      chk("n4_dir_early_valid", {31'd0, out_valid4}, 32'd0);
      @(negedge clk);
      chk("n4_dir_valid", {31'd0, out_valid4}, 32'd1);
      chk("n4_dir_y", {16'd0, out_y4}, {16'd0, exp});
      @(posedge clk); #1;
   endtask

   task automatic dir3(input int x, input logic [7:0] exp);
      send3(x, 0);
      @(negedge clk);
      @(negedge clk);
      chk("n3_dir_valid", {31'd0, out_valid3}, 32'd1);
      chk("n3_dir_y", {24'd0, out_y3}, {24'd0, exp});
      @(posedge clk); #1;
   endtask

   task automatic rand_ready4();
      while (rnd_on) begin
         @(posedge clk); #1;
         out_ready4 = 1'($urandom_range(0, 1));
      end
      out_ready4 = 1'b1;
   endtask

   int stale;
   logic [15:0] held_y;

   initial begin
      rst = 1'b1;
      in_valid4 = 1'b0; in_x4 = 4'd0; in_mode4 = 2'd0; out_ready4 = 1'b1;
      in_valid3 = 1'b0; in_x3 = 3'd0; in_mode3 = 2'd0; out_ready3 = 1'b1;
      repeat (3) @(negedge clk);
      chk("rst_out_valid", {31'd0, out_valid4}, 32'd0);
      chk("rst_in_ready", {31'd0, in_ready4}, 32'd0);
      chk("rst_out_y", {16'd0, out_y4}, 32'd0);
`ifdef HDEC_PIPE_CNT_EN
      chk("rst_out_cnt", out_cnt4, 32'd0);
`endif
      @(posedge clk); #1;
      rst = 1'b0;
      @(negedge clk);
      chk("post_rst_in_ready4", {31'd0, in_ready4}, 32'd1);
      chk("post_rst_in_ready3", {31'd0, in_ready3}, 32'd1);
      @(posedge clk); #1;

      // exhaustive streaming decode, modes 0..2, out_ready held high
      lat_chk = 1'b1;
      for (int m = 0; m < 3; m++)
         for (int x = 0; x < 16; x++) send4(x, m);
      drain("exhaustive");
      lat_chk = 1'b0;

      // boundaries and worked examples
      dir4(0, 0, 16'h0000);
      dir4(15, 0, 16'h7FFF);
      dir4(15, 1, 16'h8000);
      dir4(5, 0, 16'h001F);
      dir4(5, 1, 16'h0020);
      dir4(5, 2, 16'hFFE0);
      dir4(9, 3, 16'h0000);
      dir4(0, 3, 16'h0000);

      // backpressure: two accepts fill the pipe, output holds the first result
      out_ready4 = 1'b0;
      fork
         begin
            send4(3, 0); send4(7, 0); send4(9, 0);
         end
         begin
            repeat (6) @(negedge clk);
            chk("bp_in_ready", {31'd0, in_ready4}, 32'd0);
            chk("bp_out_valid", {31'd0, out_valid4}, 32'd1);
            chk("bp_out_y", {16'd0, out_y4}, 32'h0007);
            chk("bp_accepted", q4.size(), 32'd2);
            held_y = out_y4;
            repeat (3) @(negedge clk);
            chk("bp_hold_y", {16'd0, out_y4}, {16'd0, held_y});
            chk("bp_hold_in_ready", {31'd0, in_ready4}, 32'd0);
            @(posedge clk); #1;
            out_ready4 = 1'b1;
         end
      join
      drain("backpressure");

      // random operands and modes under random backpressure
      rnd_on = 1'b1;
      fork
         begin
            for (int k = 0; k < 150; k++) send4($urandom_range(0, 15), $urandom_range(0, 3));
            rnd_on = 1'b0;
         end
         rand_ready4();
      join
      drain("random");

      // reset asserted while both stages are full and stalled
      out_ready4 = 1'b0;
      send4(1, 1);
      send4(2, 1);
      @(negedge clk);
      chk("stall_full_in_ready", {31'd0, in_ready4}, 32'd0);
      @(posedge clk); #1;
      rst = 1'b1;
      q4.delete();
      @(negedge clk);
      chk("midrst_out_valid", {31'd0, out_valid4}, 32'd0);
      chk("midrst_out_y", {16'd0, out_y4}, 32'd0);
      chk("midrst_in_ready", {31'd0, in_ready4}, 32'd0);
      @(posedge clk); #1;
      rst = 1'b0;
      @(negedge clk);
      chk("midrst_after_in_ready", {31'd0, in_ready4}, 32'd1);
      chk("midrst_after_out_valid", {31'd0, out_valid4}, 32'd0);
      @(posedge clk); #1;
      out_ready4 = 1'b1;
      stale = 0;
      repeat (6) begin
         @(negedge clk);
         if (out_valid4) stale++;
      end
      chk("midrst_no_stale", stale, 32'd0);
      @(posedge clk); #1;

`ifdef HDEC_PIPE_CNT_EN
      chk("cnt_after_rst", out_cnt4, 32'd0);
      rnd_on = 1'b1;
      fork
         begin
            for (int k = 0; k < 20; k++) send4($urandom_range(0, 15), $urandom_range(0, 3));
            rnd_on = 1'b0;
         end
         rand_ready4();
      join
      drain("counter");
      chk("cnt_20", out_cnt4, 32'd20);
      force dut4.r_cnt = 32'hFFFF_FFFF;
      @(posedge clk); #1;
      release dut4.r_cnt;
      chk("cnt_forced", out_cnt4, 32'hFFFF_FFFF);
      send4(1, 1);
      drain("counter_wrap");
      chk("cnt_wrap", out_cnt4, 32'd0);
`endif

      // non-power-of-two width: N=3, all values in mode 0, then examples
      lat_chk = 1'b1;
      for (int x = 0; x < 8; x++) send3(x, 0);
      drain("n3_stream");
      lat_chk = 1'b0;
      dir3(3, 8'h07);
      dir3(7, 8'h7F);
      dir3(0, 8'h00);
      for (int k = 0; k < 20; k++) send3($urandom_range(0, 7), $urandom_range(0, 3));
      drain("n3_random");

      chk("final_q4_empty", q4.size(), 32'd0);
      chk("final_q3_empty", q3.size(), 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
